// File: rtl/comp_3_pkg.sv
// Shared constants and result type for the comp_3 magnitude comparator.
package comp_pkg;

    localparam int CMP_WIDTH = 3;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

endpackage

// File: rtl/comp_3_if.sv
// Operand/result bundle between a comparator client and comp_3.
interface comp_3_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output in_valid, a, b,
        input  out_valid, gt, eq, lt
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, gt, eq, lt
    );
endinterface

// File: rtl/comp_3_bit_slice.sv
// One-bit cell of the MSB-first compare cascade.
module comp_bit_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);
    logic gt_loc;
    logic eq_loc;
    logic lt_loc;

    assign gt_loc = a_i & ~b_i;
    assign lt_loc = ~a_i & b_i;
    assign eq_loc = ~(a_i ^ b_i);

    assign eq_out = eq_in & eq_loc;
    assign gt_out = gt_in | (eq_in & gt_loc);
    assign lt_out = lt_in | (eq_in & lt_loc);
endmodule

// File: rtl/comp_3.sv
// Registered unsigned magnitude comparator: slice cascade feeding a result register.
module comp_3
    import comp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    comp_3_if.slave   bus
);
    // chain index WIDTH is the implicit "equal so far" seed above the MSB
    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] eq_c;
    logic [WIDTH:0] lt_c;

    cmp_res_t res_d;
    cmp_res_t res_q;
    logic     valid_q;

    assign gt_c[WIDTH] = 1'b0;
    assign eq_c[WIDTH] = 1'b1;
    assign lt_c[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        comp_bit_slice u_slice (
            .a_i    (bus.a[i]),
            .b_i    (bus.b[i]),
            .gt_in  (gt_c[i+1]),
            .eq_in  (eq_c[i+1]),
            .lt_in  (lt_c[i+1]),
            .gt_out (gt_c[i]),
            .eq_out (eq_c[i]),
            .lt_out (lt_c[i])
        );
    end

    assign res_d = '{gt: gt_c[0], eq: eq_c[0], lt: lt_c[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.gt        = res_q.gt;
    assign bus.eq        = res_q.eq;
    assign bus.lt        = res_q.lt;
endmodule

// File: tb/tb_comp_3.sv
// Self-checking bench for comp_3: directed corners plus random traffic against an arithmetic model.
module tb_comp_3;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [2:0] exp_res;
    logic       exp_valid;

    comp_3_if #(.WIDTH(3)) bus ();

    comp_3 #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model(input int unsigned a, input int unsigned b);
        return {a > b, a == b, a < b};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.out_valid, bus.gt, bus.eq, bus.lt};
    endfunction

    // drive a pair, clock it in, update the model, then compare
    task automatic step(input string tag, input logic v, input logic [2:0] a, input logic [2:0] b);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        if (v) exp_res = model(a, b);
        exp_valid = v;
        check(tag, outs(), {exp_valid, exp_res});
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        exp_res      = 3'b000;
        exp_valid    = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        #12;
        check("reset_state", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            step("sweep", 1'b1, 3'(i / 8), 3'(i % 8));
            n_assert++;
            assert ($onehot({bus.gt, bus.eq, bus.lt}))
            else begin
                n_fail++;
                $error("FAIL onehot observed=%b expected=onehot", {bus.gt, bus.eq, bus.lt});
            end
        end

        step("b_7_0", 1'b1, 3'd7, 3'd0);
        check("b_7_0_const", outs(), 4'b1100);
        step("b_0_7", 1'b1, 3'd0, 3'd7);
        check("b_0_7_const", outs(), 4'b1001);
        step("b_7_7", 1'b1, 3'd7, 3'd7);
        check("b_7_7_const", outs(), 4'b1010);
        step("b_3_4_msb", 1'b1, 3'd3, 3'd4);
        check("b_3_4_const", outs(), 4'b1001);
        step("b_6_7_lsb", 1'b1, 3'd6, 3'd7);
        check("b_6_7_const", outs(), 4'b1001);

        step("hold_load", 1'b1, 3'd5, 3'd2);
        step("hold_drop", 1'b0, 3'd1, 3'd6);
        check("hold_const", outs(), 4'b0100);
        step("hold_keep", 1'b0, 3'd1, 3'd6);

        step("b2b_1_0", 1'b1, 3'd1, 3'd0);
        check("b2b_1_0_const", outs(), 4'b1100);
        step("b2b_0_1", 1'b1, 3'd0, 3'd1);
        check("b2b_0_1_const", outs(), 4'b1001);
        step("b2b_4_4", 1'b1, 3'd4, 3'd4);
        check("b2b_4_4_const", outs(), 4'b1010);

        bus.in_valid = 1'b0;
        bus.a        = 'x;
        bus.b        = 'x;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        check("x_iso_1", outs(), {exp_valid, exp_res});
        @(posedge clk);
        #1;
        check("x_iso_2", outs(), 4'b0010);

        step("pre_rst", 1'b1, 3'd3, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", outs(), 4'b0000);
        exp_res   = 3'b000;
        exp_valid = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 3'd2, 3'd2);
        check("post_rst_const", outs(), 4'b1010);

        for (int k = 0; k < 200; k++) begin
            step("random", ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
